// File: rtl/car_pkg.sv
// Shared types for the line-following scheduler: FSM states, steering modes, turn direction.
package car_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        TRACK   = 3'd1,
        LOST    = 3'd2,
        SEARCH  = 3'd3,
        BLOCKED = 3'd4,
        HALT    = 3'd5
    } state_e;

    localparam logic [2:0] MODE_FWD   = 3'b111;
    localparam logic [2:0] MODE_SL    = 3'b110;
    localparam logic [2:0] MODE_HL    = 3'b100;
    localparam logic [2:0] MODE_SR    = 3'b011;
    localparam logic [2:0] MODE_HR    = 3'b001;
    localparam logic [2:0] MODE_PIVOT = 3'b000;

    localparam logic LEFT  = 1'b0;
    localparam logic RIGHT = 1'b1;

    // Sensor patterns that map one-to-one onto a motor steering mode.
    function automatic logic is_track_mode(input logic [2:0] pat);
        return pat inside {MODE_FWD, MODE_SL, MODE_HL, MODE_SR, MODE_HR};
    endfunction

endpackage

// File: rtl/ir_debounce.sv
// Tick-gated debounce of the 3 IR tracker inputs; a pattern is accepted after DEB_N
// identical consecutive tick samples.
module ir_debounce #(
    parameter int DEB_N = 3
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       tick_i,
    input  logic [2:0] ir_i,
    output logic [2:0] ir_stable_o
);

    localparam int CW = (DEB_N > 1) ? $clog2(DEB_N) : 1;

    logic [2:0]    prev_q, prev_d;
    logic [2:0]    stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        prev_d   = prev_q;
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (tick_i) begin
            prev_d = ir_i;
            if (ir_i == prev_q) begin
                if (cnt_q != CW'(DEB_N - 1)) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                cnt_d = '0;
            end
            // Saturated count means the pattern has held for DEB_N samples.
            if (cnt_d == CW'(DEB_N - 1)) begin
                stable_d = ir_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            prev_q   <= 3'b111;
            stable_q <= 3'b111;
            cnt_q    <= '0;
        end else begin
            prev_q   <= prev_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign ir_stable_o = stable_q;

endmodule

// File: rtl/track_mode_sched.sv
// Line-following scheduler: tick divider, obstacle flag with hysteresis and the
// steering FSM producing registered mode/halt for the motor block.
module track_mode_sched
    import car_pkg::*;
#(
    parameter int         TICK_DIV     = 4096,
    parameter int         DEB_N        = 3,
    parameter int         LOST_TICKS   = 64,
    parameter int         SEARCH_TICKS = 512,
    parameter logic [9:0] STOP_CM      = 10'd20,
    parameter logic [9:0] HYST_CM      = 10'd5
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic [2:0] ir_i,
    input  logic [9:0] dist_cm_i,
    input  logic       dist_valid_i,
    output logic [2:0] mode_o,
    output logic       halt_o,
    output logic [2:0] state_o
);

    localparam int TW = (TICK_DIV > 1)     ? $clog2(TICK_DIV)     : 1;
    localparam int LW = (LOST_TICKS > 1)   ? $clog2(LOST_TICKS)   : 1;
    localparam int SW = (SEARCH_TICKS > 1) ? $clog2(SEARCH_TICKS) : 1;

    localparam logic [10:0] STOP_EXT    = {1'b0, STOP_CM};
    localparam logic [10:0] RELEASE_EXT = {1'b0, STOP_CM} + {1'b0, HYST_CM};

    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic          tick;
    logic          blk_flag_q, blk_flag_d;
    logic [2:0]    ir_stable;
    state_e        state_q, state_d;
    logic [2:0]    mode_q, mode_d;
    logic          halt_q, halt_d;
    logic          last_dir_q, last_dir_d;
    logic [LW-1:0] lost_cnt_q, lost_cnt_d;
    logic [SW-1:0] search_cnt_q, search_cnt_d;
    logic [10:0]   dist_ext;

    ir_debounce #(.DEB_N(DEB_N)) u_ir_debounce (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .tick_i      (tick),
        .ir_i        (ir_i),
        .ir_stable_o (ir_stable)
    );

    assign tick       = (tick_cnt_q == TW'(TICK_DIV - 1));
    assign tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    assign dist_ext   = {1'b0, dist_cm_i};

    // Between the stop and release thresholds the flag keeps its previous value.
    always_comb begin
        blk_flag_d = blk_flag_q;
        if (dist_valid_i) begin
            if (dist_ext < STOP_EXT) begin
                blk_flag_d = 1'b1;
            end else if (dist_ext >= RELEASE_EXT) begin
                blk_flag_d = 1'b0;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        last_dir_d   = last_dir_q;
        lost_cnt_d   = lost_cnt_q;
        search_cnt_d = search_cnt_q;

        if (!en_i) begin
            state_d = IDLE;
        end else if (blk_flag_q && (state_q inside {TRACK, LOST, SEARCH})) begin
            state_d = BLOCKED;
        end else if (tick) begin
            unique case (state_q)
                IDLE: state_d = TRACK;
                TRACK: begin
                    if (ir_stable == MODE_PIVOT) begin
                        state_d    = LOST;
                        mode_d     = MODE_PIVOT;
                        lost_cnt_d = '0;
                    end else if (is_track_mode(ir_stable)) begin
                        mode_d = ir_stable;
                        if (ir_stable == MODE_SL || ir_stable == MODE_HL) begin
                            last_dir_d = LEFT;
                        end else if (ir_stable == MODE_SR || ir_stable == MODE_HR) begin
                            last_dir_d = RIGHT;
                        end
                    end
                end
                LOST: begin
                    // Reacquiring the line takes precedence over escalation.
                    if (ir_stable != MODE_PIVOT) begin
                        state_d = TRACK;
                    end else if (lost_cnt_q == LW'(LOST_TICKS - 1)) begin
                        state_d      = SEARCH;
                        search_cnt_d = '0;
                        mode_d       = (last_dir_q == LEFT) ? MODE_HL : MODE_HR;
                    end else begin
                        lost_cnt_d = lost_cnt_q + 1'b1;
                    end
                end
                SEARCH: begin
                    if (ir_stable != MODE_PIVOT) begin
                        state_d = TRACK;
                    end else if (search_cnt_q == SW'(SEARCH_TICKS - 1)) begin
                        state_d = HALT;
                        mode_d  = MODE_FWD;
                    end else begin
                        search_cnt_d = search_cnt_q + 1'b1;
                    end
                end
                BLOCKED: begin
                    if (!blk_flag_q) begin
                        state_d = TRACK;
                    end
                end
                default: ;
            endcase
        end

        if (state_q == IDLE || state_q == BLOCKED) begin
            lost_cnt_d   = '0;
            search_cnt_d = '0;
        end

        halt_d = (state_d == IDLE) || (state_d == BLOCKED) || (state_d == HALT);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            tick_cnt_q   <= '0;
            blk_flag_q   <= 1'b0;
            state_q      <= IDLE;
            mode_q       <= MODE_FWD;
            halt_q       <= 1'b1;
            last_dir_q   <= LEFT;
            lost_cnt_q   <= '0;
            search_cnt_q <= '0;
        end else begin
            tick_cnt_q   <= tick_cnt_d;
            blk_flag_q   <= blk_flag_d;
            state_q      <= state_d;
            mode_q       <= mode_d;
            halt_q       <= halt_d;
            last_dir_q   <= last_dir_d;
            lost_cnt_q   <= lost_cnt_d;
            search_cnt_q <= search_cnt_d;
        end
    end

    assign mode_o  = mode_q;
    assign halt_o  = halt_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_track_mode_sched.sv
// Self-checking bench for track_mode_sched with a cycle-level behavioural reference.
module tb_track_mode_sched;

    localparam int TD = 8, DN = 3, LT = 4, ST = 6;
    localparam int STOP = 20, REL = 25;
    localparam logic [2:0] S_IDLE = 3'd0, S_TRACK = 3'd1, S_LOST = 3'd2,
                           S_SEARCH = 3'd3, S_BLOCKED = 3'd4, S_HALT = 3'd5;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic [2:0] ir = 3'b111;
    logic [9:0] dist_cm = '0;
    logic       dist_valid = 1'b0;
    logic [2:0] mode, state;
    logic       halt;

    int vecs = 0;
    int errs = 0;

    track_mode_sched #(
        .TICK_DIV(TD), .DEB_N(DN), .LOST_TICKS(LT), .SEARCH_TICKS(ST),
        .STOP_CM(10'd20), .HYST_CM(10'd5)
    ) dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .ir_i(ir),
        .dist_cm_i(dist_cm), .dist_valid_i(dist_valid),
        .mode_o(mode), .halt_o(halt), .state_o(state)
    );

    always #5 clk = ~clk;

    // Reference model: tick = every TD-th cycle since reset, debounce as a run length
    // of identical tick samples, state durations counted in ticks.
    logic [2:0] m_state, m_mode, m_stable, m_run_val;
    logic       m_halt, m_blk;
    bit         m_left, m_tick;
    int         m_run_len, m_lost, m_search, m_cyc;

    always @(posedge clk) begin
        if (!rst) begin
            m_state = S_IDLE; m_mode = 3'b111; m_halt = 1'b1; m_blk = 1'b0;
            m_stable = 3'b111; m_run_val = 3'b111; m_run_len = 1;
            m_left = 1'b1; m_lost = 0; m_search = 0; m_cyc = 0;
        end else begin
            m_tick = ((m_cyc % TD) == TD - 1);
            m_cyc++;
            if (!en) m_state = S_IDLE;
            else if (m_blk && (m_state == S_TRACK || m_state == S_LOST || m_state == S_SEARCH))
                m_state = S_BLOCKED;
            else if (m_tick) begin
                case (m_state)
                    S_IDLE: m_state = S_TRACK;
                    S_TRACK:
                        if (m_stable == 3'b000) begin
                            m_state = S_LOST; m_mode = 3'b000; m_lost = 0;
                        end else if (m_stable inside {3'b111, 3'b110, 3'b100, 3'b011, 3'b001}) begin
                            m_mode = m_stable;
                            if (m_stable == 3'b110 || m_stable == 3'b100) m_left = 1'b1;
                            else if (m_stable != 3'b111) m_left = 1'b0;
                        end
                    S_LOST:
                        if (m_stable != 3'b000) m_state = S_TRACK;
                        else if (m_lost + 1 == LT) begin
                            m_state = S_SEARCH; m_search = 0;
                            m_mode = m_left ? 3'b100 : 3'b001;
                        end else m_lost++;
                    S_SEARCH:
                        if (m_stable != 3'b000) m_state = S_TRACK;
                        else if (m_search + 1 == ST) begin
                            m_state = S_HALT; m_mode = 3'b111;
                        end else m_search++;
                    S_BLOCKED: if (!m_blk) m_state = S_TRACK;
                    default: ;
                endcase
            end
            m_halt = (m_state == S_IDLE || m_state == S_BLOCKED || m_state == S_HALT);
            if (m_tick) begin
                if (ir == m_run_val) begin
                    if (m_run_len < 1000) m_run_len++;
                end else begin
                    m_run_val = ir; m_run_len = 1;
                end
                if (m_run_len >= DN) m_stable = ir;
            end
            if (dist_valid) begin
                if (int'(dist_cm) < STOP) m_blk = 1'b1;
                else if (int'(dist_cm) >= REL) m_blk = 1'b0;
            end
        end
    end

    task automatic strobe(input logic [9:0] d);
        dist_cm = d; dist_valid = 1'b1;
        @(negedge clk);
        dist_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0; en = 1'b0; ir = 3'b111;
        repeat (3) @(negedge clk);
        vecs++; if (state !== S_IDLE) begin errs++; $display("FAIL reset_state: got %0d want %0d", state, S_IDLE); end
        vecs++; if (mode !== 3'b111) begin errs++; $display("FAIL reset_mode: got %b want 111", mode); end
        vecs++; if (halt !== 1'b1) begin errs++; $display("FAIL reset_halt: got %b want 1", halt); end
        rst = 1'b1;
    endtask

    task automatic test_track_glitch;
        int bad_mode = 0;
        en = 1'b1;
        for (int i = 0; i < TD && state !== S_TRACK; i++) begin
            @(negedge clk);
            vecs++; if ({state, mode, halt} !== {m_state, m_mode, m_halt}) begin errs++;
                $display("FAIL enter_track: got st=%0d mode=%b halt=%b want st=%0d mode=%b halt=%b", state, mode, halt, m_state, m_mode, m_halt); end
        end
        vecs++; if (state !== S_TRACK || halt !== 1'b0) begin errs++; $display("FAIL track_within_tick: got st=%0d halt=%b want st=1 halt=0", state, halt); end
        repeat ($urandom_range(0, TD - 1)) @(negedge clk);
        ir = 3'b110;
        repeat (TD) @(negedge clk);
        ir = 3'b111;
        for (int i = 0; i < 5 * TD; i++) begin
            @(negedge clk);
            if (mode !== 3'b111) bad_mode++;
            vecs++; if ({state, mode, halt} !== {m_state, m_mode, m_halt}) begin errs++;
                $display("FAIL glitch_cycle: got st=%0d mode=%b halt=%b want st=%0d mode=%b halt=%b", state, mode, halt, m_state, m_mode, m_halt); end
        end
        vecs++; if (bad_mode !== 0) begin errs++; $display("FAIL glitch_leak: got %0d cycles with mode!=111 want 0", bad_mode); end
    endtask

    task automatic test_lost_search_halt;
        int lost_cyc = 0, search_cyc = 0, bad = 0;
        ir = 3'b110;
        for (int i = 0; i < 5 * TD; i++) begin
            @(negedge clk);
            vecs++; if ({state, mode, halt} !== {m_state, m_mode, m_halt}) begin errs++;
                $display("FAIL left_track: got st=%0d mode=%b halt=%b want st=%0d mode=%b halt=%b", state, mode, halt, m_state, m_mode, m_halt); end
        end
        vecs++; if (mode !== 3'b110) begin errs++; $display("FAIL mode_sl: got %b want 110", mode); end
        ir = 3'b000;
        for (int i = 0; i < 25 * TD && state !== S_HALT; i++) begin
            @(negedge clk);
            if (state == S_LOST) begin lost_cyc++; if (mode !== 3'b000 || halt !== 1'b0) bad++; end
            if (state == S_SEARCH) begin search_cyc++; if (mode !== 3'b100 || halt !== 1'b0) bad++; end
            vecs++; if ({state, mode, halt} !== {m_state, m_mode, m_halt}) begin errs++;
                $display("FAIL loss_seq: got st=%0d mode=%b halt=%b want st=%0d mode=%b halt=%b", state, mode, halt, m_state, m_mode, m_halt); end
        end
        vecs++; if (state !== S_HALT) begin errs++; $display("FAIL halt_reached: got st=%0d want %0d (timeout)", state, S_HALT); end
        vecs++; if (halt !== 1'b1 || mode !== 3'b111) begin errs++; $display("FAIL halt_outputs: got halt=%b mode=%b want 1/111", halt, mode); end
        vecs++; if (lost_cyc !== LT * TD) begin errs++; $display("FAIL lost_duration: got %0d want %0d cycles", lost_cyc, LT * TD); end
        vecs++; if (search_cyc !== ST * TD) begin errs++; $display("FAIL search_duration: got %0d want %0d cycles", search_cyc, ST * TD); end
        vecs++; if (bad !== 0) begin errs++; $display("FAIL lost_search_mode: got %0d bad cycles want 0", bad); end
        en = 1'b0; ir = 3'b111;
        @(negedge clk);
        vecs++; if (state !== S_IDLE || halt !== 1'b1) begin errs++; $display("FAIL halt_exit: got st=%0d halt=%b want 0/1", state, halt); end
    endtask

    task automatic test_reacquire;
        int lost_cyc = 0;
        en = 1'b1; ir = 3'b110;
        repeat (5 * TD) @(negedge clk);
        ir = 3'b000;
        for (int i = 0; i < 12 * TD && state !== S_SEARCH; i++) @(negedge clk);
        vecs++; if (state !== S_SEARCH || mode !== 3'b100) begin errs++; $display("FAIL search_left: got st=%0d mode=%b want 3/100", state, mode); end
        repeat ($urandom_range(0, TD)) @(negedge clk);
        ir = 3'b011;
        for (int i = 0; i < 5 * TD && state !== S_TRACK; i++) begin
            @(negedge clk);
            vecs++; if ({state, mode, halt} !== {m_state, m_mode, m_halt}) begin errs++;
                $display("FAIL reacq_seq: got st=%0d mode=%b halt=%b want st=%0d mode=%b halt=%b", state, mode, halt, m_state, m_mode, m_halt); end
        end
        vecs++; if (state !== S_TRACK) begin errs++; $display("FAIL reacq_track: got st=%0d want 1 (timeout)", state); end
        repeat (TD) @(negedge clk);
        vecs++; if (mode !== 3'b011) begin errs++; $display("FAIL reacq_mode: got %b want 011", mode); end
        ir = 3'b000;
        for (int i = 0; i < 12 * TD && state !== S_SEARCH; i++) begin
            @(negedge clk);
            if (state == S_LOST) lost_cyc++;
        end
        vecs++; if (lost_cyc !== LT * TD) begin errs++; $display("FAIL fresh_loss: got %0d want %0d cycles", lost_cyc, LT * TD); end
        vecs++; if (mode !== 3'b001) begin errs++; $display("FAIL search_right: got %b want 001", mode); end
        ir = 3'b111;
        for (int i = 0; i < 6 * TD && state !== S_TRACK; i++) @(negedge clk);
        vecs++; if (state !== S_TRACK) begin errs++; $display("FAIL back_to_track: got st=%0d want 1", state); end
    endtask

    task automatic test_obstacle;
        strobe(10'(STOP));
        repeat (3) @(negedge clk);
        vecs++; if (state !== S_TRACK) begin errs++; $display("FAIL dist_at_stop: got st=%0d want 1", state); end
        strobe(10'($urandom_range(0, STOP - 1)));
        @(negedge clk);
        vecs++; if (state !== S_BLOCKED || halt !== 1'b1) begin errs++; $display("FAIL blocked: got st=%0d halt=%b want 4/1", state, halt); end
        strobe(10'(REL - 1));
        strobe(10'($urandom_range(STOP, REL - 1)));
        for (int i = 0; i < 2 * TD; i++) begin
            @(negedge clk);
            vecs++; if ({state, mode, halt} !== {m_state, m_mode, m_halt}) begin errs++;
                $display("FAIL hyst_hold: got st=%0d mode=%b halt=%b want st=%0d mode=%b halt=%b", state, mode, halt, m_state, m_mode, m_halt); end
        end
        vecs++; if (state !== S_BLOCKED) begin errs++; $display("FAIL hyst_blocked: got st=%0d want 4", state); end
        strobe(($urandom_range(0, 1) == 0) ? 10'(REL) : 10'($urandom_range(REL, 1023)));
        for (int i = 0; i < TD + 2 && state !== S_TRACK; i++) @(negedge clk);
        vecs++; if (state !== S_TRACK || halt !== 1'b0) begin errs++; $display("FAIL release: got st=%0d halt=%b want 1/0", state, halt); end
    endtask

    task automatic test_en_override;
        en = 1'b0;
        strobe(10'd5);
        vecs++; if (state !== S_IDLE || halt !== 1'b1) begin errs++; $display("FAIL en_over_blk: got st=%0d halt=%b want 0/1", state, halt); end
        repeat (2 * TD) @(negedge clk);
        vecs++; if (state !== S_IDLE) begin errs++; $display("FAIL idle_hold: got st=%0d want 0", state); end
        strobe(10'd100);
        en = 1'b1; ir = 3'b000;
        for (int i = 0; i < 15 * TD && state !== S_SEARCH; i++) @(negedge clk);
        repeat ($urandom_range(1, 2 * TD)) @(negedge clk);
        vecs++; if (state !== S_SEARCH) begin errs++; $display("FAIL pre_rst_search: got st=%0d want 3", state); end
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1; ir = 3'b111;
        vecs++; if (state !== S_IDLE || mode !== 3'b111 || halt !== 1'b1) begin errs++;
            $display("FAIL mid_reset: got st=%0d mode=%b halt=%b want 0/111/1", state, mode, halt); end
    endtask

    task automatic test_invalid_pattern;
        int bad = 0;
        repeat (2 * TD) @(negedge clk);
        for (int p = 0; p < 2; p++) begin
            ir = (p == 0) ? 3'b010 : 3'b101;
            for (int i = 0; i < 6 * TD; i++) begin
                @(negedge clk);
                if (state !== S_TRACK || mode !== 3'b111) bad++;
                vecs++; if ({state, mode, halt} !== {m_state, m_mode, m_halt}) begin errs++;
                    $display("FAIL invalid_seq: got st=%0d mode=%b halt=%b want st=%0d mode=%b halt=%b", state, mode, halt, m_state, m_mode, m_halt); end
            end
        end
        vecs++; if (bad !== 0) begin errs++; $display("FAIL invalid_hold: got %0d bad cycles want 0", bad); end
        ir = 3'b111;
    endtask

    task automatic test_random_soak;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            vecs++; if ({state, mode, halt} !== {m_state, m_mode, m_halt}) begin errs++;
                $display("FAIL soak@%0d: got st=%0d mode=%b halt=%b want st=%0d mode=%b halt=%b", i, state, mode, halt, m_state, m_mode, m_halt); end
            rst = ($urandom_range(0, 599) != 0);
            if ($urandom_range(0, 299) == 0) en = ~en;
            else if (!en && $urandom_range(0, 49) == 0) en = 1'b1;
            if ($urandom_range(0, 39) == 0) ir = ($urandom_range(0, 2) == 0) ? 3'b000 : 3'($urandom_range(0, 7));
            dist_valid = ($urandom_range(0, 59) == 0);
            dist_cm = 10'($urandom_range(0, 40));
        end
        dist_valid = 1'b0; rst = 1'b1;
    endtask

    initial begin
        test_reset();
        test_track_glitch();
        test_lost_search_halt();
        test_reacquire();
        test_obstacle();
        test_en_override();
        test_invalid_pattern();
        test_random_soak();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/track_mode_sched.md
Name: track_mode_sched

Overview:
- Line-following scheduler that produces the 3-bit steering mode consumed by the dual-motor PWM block.
- Debounces the three IR tracker sensors and sequences recovery when the line is lost.
- Overrides motion when the ultrasonic range reading reports an obstacle.
- Sits between the sensor front-end (IR pins, sonic ranger) and the motor block; `halt` gates the motor enables at top level.

Parameters:
- TICK_DIV, 4096: clk cycles per scheduler tick; matches the motor block's speed-update cadence.
- DEB_N, 3: consecutive identical tick samples required before the IR pattern is accepted.
- LOST_TICKS, 64: ticks spent in LOST before escalating to SEARCH.
- SEARCH_TICKS, 512: ticks spent in SEARCH before giving up to HALT.
- STOP_CM, 10'd20: obstacle distance threshold, in cm.
- HYST_CM, 10'd5: release hysteresis; resume only at distance >= STOP_CM+HYST_CM.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low; sampled on posedge clk
- en  in  1  run switch, 1 = drive, level-sensitive
- ir  in  3  raw tracker sensors {left, mid, right}, 1 = line under sensor
- dist_cm  in  10  latest ultrasonic distance in cm
- dist_valid  in  1  1-cycle strobe; dist_cm is valid on this cycle
- mode  out  3  steering mode to the motor block
- halt  out  1  1 = motors must be gated off
- state  out  3  FSM state, for LED debug

Behaviour:
- Reset (rst=0 at posedge): state=IDLE, mode=3'b111, halt=1, tick counter=0, ir_stable=3'b111, deb count=0, last_dir=LEFT, lost/search counters=0, blk_flag=0.
- Tick:
  - Free-running counter over 0..TICK_DIV-1; `tick` is high for one cycle when the counter wraps.
  - The counter runs in every state.
- Debounce, evaluated on tick only:
  - If ir equals the previous tick sample, deb count increments, saturating at DEB_N-1.
  - Otherwise deb count clears.
  - When deb count reaches DEB_N-1, ir_stable<=ir.
  - ir_stable therefore changes no earlier than DEB_N ticks after ir settles.
- Obstacle flag (any cycle):
  - On dist_valid with dist_cm < STOP_CM: blk_flag<=1.
  - On dist_valid with dist_cm >= STOP_CM+HYST_CM: blk_flag<=0.
  - Values in between hold the flag.
- State encoding: IDLE=0, TRACK=1, LOST=2, SEARCH=3, BLOCKED=4, HALT=5.
- Transition priority:
  1. en=0 -> IDLE on the next clk edge, from any state, not tick-gated.
  2. blk_flag=1 in TRACK, LOST or SEARCH -> BLOCKED on the next clk edge.
  3. All other transitions are evaluated on tick only.
- IDLE:
  - halt=1, mode holds its value.
  - en=1 -> TRACK.
  - Lost/search counters are cleared.
- TRACK:
  - halt=0.
  - ir_stable in {111,110,100,011,001} -> mode<=ir_stable.
  - 110 or 100 -> last_dir<=LEFT; 011 or 001 -> last_dir<=RIGHT; 111 leaves last_dir unchanged.
  - ir_stable in {010,101} is invalid: mode holds its value.
  - ir_stable=000 -> LOST, mode<=000, lost_cnt<=0.
- LOST:
  - halt=0, mode=000 (motor pivot-hold).
  - ir_stable!=000 -> TRACK.
  - Otherwise, when lost_cnt==LOST_TICKS-1 -> SEARCH with search_cnt<=0; else lost_cnt++.
- SEARCH:
  - halt=0, mode = (last_dir==LEFT) ? 100 : 001.
  - ir_stable!=000 -> TRACK.
  - Otherwise, when search_cnt==SEARCH_TICKS-1 -> HALT; else search_cnt++.
- BLOCKED:
  - halt=1, mode holds its value.
  - blk_flag=0 -> TRACK on the next tick; re-entry always goes to TRACK, and counters are cleared.
- HALT:
  - halt=1, mode=111.
  - Exits only via en=0 -> IDLE.
- Simultaneous events:
  - en=0 and blk_flag=1 -> IDLE.
  - Tick with ir_stable!=000 in LOST on the same cycle lost_cnt hits its limit -> TRACK (reacquire wins).
- Reset mid-operation returns to the reset values above on the same edge.
- `mode` and `halt` are registered; combinational paths from inputs to outputs are not allowed.
- Counter widths are $clog2 of the respective parameter. Distance comparisons are unsigned 11-bit so STOP_CM+HYST_CM cannot overflow.

Decomposition:
- Shared package (car_pkg):
  - state enum constants.
  - Mode constants: MODE_FWD=111, MODE_SL=110, MODE_HL=100, MODE_SR=011, MODE_HR=001, MODE_PIVOT=000.
  - LEFT/RIGHT direction constants.
- Sub-module `ir_debounce`: owns the tick-gated debounce of the 3-bit ir input; inputs clk, rst, tick, ir; output ir_stable.
- The FSM, tick divider and obstacle flag stay in track_mode_sched.

Test Plan (all scenarios with TICK_DIV=8, DEB_N=3, LOST_TICKS=4, SEARCH_TICKS=6):
1. Reset, en=1, ir=111 held -> state TRACK one tick after en; mode=111 and halt=0; a glitch of ir=110 lasting 1 tick never reaches mode.
2. ir=110 stable for 3 ticks, then ir=000 -> mode goes 110 (last_dir=LEFT), then 000 in LOST; after 4 ticks mode=100 in SEARCH; after 6 more ticks state=HALT with halt=1 and mode=111.
3. In SEARCH, ir=011 held 3 ticks -> TRACK with mode=011; lost/search counters reset (a fresh loss takes the full 4 ticks again).
4. In TRACK, dist_valid with dist_cm=19 -> BLOCKED next cycle with halt=1; dist_cm=22 -> remains BLOCKED; dist_cm=25 -> TRACK on the next tick with halt=0.
5. In any non-IDLE state drive en=0 together with dist_cm=5 strobe -> IDLE next cycle with halt=1; pull rst low mid-SEARCH -> mode=111, state=IDLE on that edge.
6. ir=010 stable in TRACK -> mode holds its previous value 111 and state stays TRACK.
